// File: rtl/smvm_batch_scheduler.sv
`default_nettype none
// smvm_batch_scheduler: packs a serial nonzero stream into K-lane batches with IPV bits for the SMVM ALU tree.
// Define SMVM_SCHED_PERF_EN to add the perf_batches / perf_stall counters.
module smvm_batch_scheduler #(
  parameter int K       = 4,
  parameter int VAL_W   = 8,
  parameter int COL_W   = 9,
  parameter int ROW_W   = 9,
  parameter int ALU_LAT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [ROW_W-1:0]   num_rows,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VAL_W-1:0]   in_val,
  input  logic [COL_W-1:0]   in_col,
  input  logic               in_last,
  input  logic               in_eom,
  output logic               batch_valid,
  input  logic               batch_ready,
  output logic [K*VAL_W-1:0] batch_val,
  output logic [K*COL_W-1:0] batch_col,
  output logic [K-1:0]       batch_ipv,
  output logic [2:0]         batch_rows,
  output logic               busy,
  output logic               done,
`ifdef SMVM_SCHED_PERF_EN
  output logic [15:0]        perf_batches,
  output logic [15:0]        perf_stall,
`endif
  output logic               err_rows
);

  localparam int LCW = (K > 1) ? $clog2(K) : 1;
  localparam int DCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam int RSW = ROW_W + 1;
  localparam logic [LCW-1:0] LANE_LAST  = LCW'(K - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_ISSUE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [VAL_W-1:0]   val_q [K];
  logic [COL_W-1:0]   col_q [K];
  logic [K-1:0]       ipv_q;
  logic [2:0]         rows_q;
  logic [LCW-1:0]     lane_cnt;
  logic [DCW-1:0]     drain_cnt;
  logic [ROW_W-1:0]   row_cnt;
  logic [ROW_W-1:0]   num_rows_q;
  logic               eom_seen;
  logic               accept;
  logic               fire;
  logic               row_end;
  logic [RSW-1:0]     row_sum;

  assign accept  = (state == S_FILL) && in_valid;
  assign fire    = (state == S_ISSUE) && batch_ready;
  assign row_end = in_last | in_eom;
  assign row_sum = {1'b0, row_cnt} + RSW'(rows_q);

  assign in_ready    = (state == S_FILL);
  assign batch_valid = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = (num_rows != '0) ? S_FILL : S_DONE;
      S_FILL:  if (accept && (in_eom || lane_cnt == LANE_LAST)) state_nx = S_ISSUE;
      S_ISSUE: if (batch_ready) state_nx = eom_seen ? S_DRAIN : S_FILL;
      S_DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Lane buffer only changes in FILL, so the batch is inherently stable while stalled in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < K; i++) begin
        val_q[i] <= '0;
        col_q[i] <= '0;
      end
      ipv_q      <= '0;
      rows_q     <= '0;
      lane_cnt   <= '0;
      drain_cnt  <= '0;
      row_cnt    <= '0;
      num_rows_q <= '0;
      eom_seen   <= 1'b0;
      err_rows   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          for (int i = 0; i < K; i++) begin
            val_q[i] <= '0;
            col_q[i] <= '0;
          end
          ipv_q      <= '0;
          rows_q     <= '0;
          lane_cnt   <= '0;
          drain_cnt  <= '0;
          row_cnt    <= '0;
          num_rows_q <= num_rows;
          eom_seen   <= 1'b0;
          err_rows   <= 1'b0;
        end
        S_FILL: if (accept) begin
          val_q[lane_cnt] <= in_val;
          col_q[lane_cnt] <= in_col;
          ipv_q[lane_cnt] <= row_end;
          rows_q          <= rows_q + 3'(row_end);
          lane_cnt        <= lane_cnt + 1'b1;
          if (in_eom) eom_seen <= 1'b1;
        end
        S_ISSUE: if (fire) begin
          for (int i = 0; i < K; i++) begin
            val_q[i] <= '0;
            col_q[i] <= '0;
          end
          ipv_q     <= '0;
          rows_q    <= '0;
          lane_cnt  <= '0;
          drain_cnt <= '0;
          row_cnt   <= row_sum[ROW_W] ? {ROW_W{1'b1}} : row_sum[ROW_W-1:0];
        end
        S_DRAIN: begin
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == DRAIN_LAST) err_rows <= (row_cnt != num_rows_q);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    batch_val  = '0;
    batch_col  = '0;
    batch_ipv  = '0;
    batch_rows = '0;
    if (batch_valid) begin
      for (int i = 0; i < K; i++) begin
        batch_val[i*VAL_W +: VAL_W] = val_q[i];
        batch_col[i*COL_W +: COL_W] = col_q[i];
      end
      batch_ipv  = ipv_q;
      batch_rows = rows_q;
    end
  end

`ifdef SMVM_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_batches <= '0;
      perf_stall   <= '0;
    end else if (state == S_IDLE && start) begin
      perf_batches <= '0;
      perf_stall   <= '0;
    end else if (state == S_ISSUE) begin
      if (batch_ready) begin
        if (perf_batches != 16'hFFFF) perf_batches <= perf_batches + 16'd1;
      end else begin
        if (perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_smvm_batch_scheduler.sv
`default_nettype none
// tb_smvm_batch_scheduler: directed and randomized checks of the batch scheduler against a chunking model.
module tb_smvm_batch_scheduler;

  localparam int K       = 4;
  localparam int VAL_W   = 8;
  localparam int COL_W   = 9;
  localparam int ROW_W   = 9;
  localparam int ALU_LAT = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic [ROW_W-1:0]   num_rows;
  logic               in_valid;
  logic               in_ready;
  logic [VAL_W-1:0]   in_val;
  logic [COL_W-1:0]   in_col;
  logic               in_last;
  logic               in_eom;
  logic               batch_valid;
  logic               batch_ready;
  logic [K*VAL_W-1:0] batch_val;
  logic [K*COL_W-1:0] batch_col;
  logic [K-1:0]       batch_ipv;
  logic [2:0]         batch_rows;
  logic               busy;
  logic               done;
  logic               err_rows;
`ifdef SMVM_SCHED_PERF_EN
  logic [15:0]        perf_batches;
  logic [15:0]        perf_stall;
`endif

  int total = 0;
  int bad   = 0;

  logic [VAL_W-1:0] q_val [$];
  logic [COL_W-1:0] q_col [$];
  bit               q_last[$];

  smvm_batch_scheduler #(
    .K(K), .VAL_W(VAL_W), .COL_W(COL_W), .ROW_W(ROW_W), .ALU_LAT(ALU_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows),
    .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val), .in_col(in_col),
    .in_last(in_last), .in_eom(in_eom),
    .batch_valid(batch_valid), .batch_ready(batch_ready), .batch_val(batch_val),
    .batch_col(batch_col), .batch_ipv(batch_ipv), .batch_rows(batch_rows),
    .busy(busy), .done(done),
`ifdef SMVM_SCHED_PERF_EN
    .perf_batches(perf_batches), .perf_stall(perf_stall),
`endif
    .err_rows(err_rows)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_entry(input bit last);
    q_val.push_back(VAL_W'($urandom));
    q_col.push_back(COL_W'($urandom));
    q_last.push_back(last);
  endtask

  // Random stream of n entries; returns the number of row ends it carries (eom forces one).
  task automatic gen_stream(input int n, output int rows);
    bit l;
    q_val.delete(); q_col.delete(); q_last.delete();
    rows = 0;
    for (int i = 0; i < n; i++) begin
      l = ($urandom_range(0, 99) < 35);
      push_entry(l);
      if (l || i == n - 1) rows++;
    end
  endtask

  // rmode: 0 = always ready, 1 = random ready, 2 = hold ready low stall_len cycles on first batch
  task automatic run_matrix(input int nrows, input int rmode, input int stall_len);
    logic [K*VAL_W-1:0] eb_val[$];
    logic [K*COL_W-1:0] eb_col[$];
    logic [K-1:0]       eb_ipv[$];
    logic [2:0]         eb_rows[$];
    logic [K*VAL_W-1:0] cv;
    logic [K*COL_W-1:0] cc;
    logic [K-1:0]       ci;
    int  lane, tot, n, idx, cyc, hs, nb, nbexp, stalls, held;
    bit  eom, exp_err, got_done, r;

    n = q_val.size();
    cv = '0; cc = '0; ci = '0; lane = 0; tot = 0;
    for (int i = 0; i < n; i++) begin
      eom = (i == n - 1);
      cv[lane*VAL_W +: VAL_W] = q_val[i];
      cc[lane*COL_W +: COL_W] = q_col[i];
      ci[lane] = q_last[i] | eom;
      lane++;
      if (lane == K || eom) begin
        eb_val.push_back(cv);
        eb_col.push_back(cc);
        eb_ipv.push_back(ci);
        eb_rows.push_back(3'($countones(ci)));
        tot += $countones(ci);
        cv = '0; cc = '0; ci = '0; lane = 0;
      end
    end
    if (tot > (1 << ROW_W) - 1) tot = (1 << ROW_W) - 1;
    exp_err = (tot != nrows);
    nbexp = eb_val.size();

    idx = 0; cyc = 0; hs = -1000; nb = 0; stalls = 0; held = 0; got_done = 1'b0;
    @(negedge clk);
    start = 1'b1;
    num_rows = ROW_W'(nrows);
    while (!got_done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      check("busy_run", busy, 1'b1);
      if (batch_valid) begin
        check("ready_excl", in_ready, 1'b0);
        if (eb_val.size() == 0) check("extra_batch", 1'b1, 1'b0);
        else begin
          check("batch_val",  batch_val,  eb_val[0]);
          check("batch_col",  batch_col,  eb_col[0]);
          check("batch_ipv",  batch_ipv,  eb_ipv[0]);
          check("batch_rows", batch_rows, eb_rows[0]);
        end
      end else begin
        check("idle_val_ipv", {batch_ipv, batch_rows, batch_val}, '0);
        check("idle_col", batch_col, '0);
      end
      if (done) begin
        got_done = 1'b1;
        check("err_rows", err_rows, exp_err);
        check("done_latency", 64'(cyc - hs), 64'(ALU_LAT + 1));
        check("batches_left", 64'(eb_val.size()), 64'd0);
        check("batch_count", 64'(nb), 64'(nbexp));
        check("entries_used", 64'(idx), 64'(n));
`ifdef SMVM_SCHED_PERF_EN
        check("perf_batches", perf_batches, 16'(nb));
        check("perf_stall", perf_stall, 16'(stalls));
`endif
      end

      start = !done && ($urandom_range(0, 7) == 0);
      num_rows = ROW_W'($urandom);
      if (batch_valid) begin
        if (rmode == 0) r = 1'b1;
        else if (rmode == 2) begin
          r = (held >= stall_len);
          if (!r) held++;
        end else r = ($urandom_range(0, 2) != 0);
        batch_ready = r;
        if (r) begin
          if (eb_val.size() != 0) begin
            eb_val.delete(0); eb_col.delete(0); eb_ipv.delete(0); eb_rows.delete(0);
          end
          hs = cyc;
          nb++;
        end else stalls++;
      end else batch_ready = 1'($urandom_range(0, 1));
      if (in_ready && idx < n && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        in_val   = q_val[idx];
        in_col   = q_col[idx];
        in_last  = q_last[idx];
        in_eom   = (idx == n - 1);
        idx++;
      end else begin
        in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
        in_val   = VAL_W'($urandom);
        in_col   = COL_W'($urandom);
        in_last  = 1'($urandom_range(0, 1));
        in_eom   = 1'($urandom_range(0, 1));
      end
    end
    if (!got_done) check("done_timeout", 1'b0, 1'b1);
    if (rmode == 2) check("stall_applied", 64'(stalls), 64'(stall_len));
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; batch_ready = 1'b0;
    check("done_one_cycle", done, 1'b0);
    check("busy_after", busy, 1'b0);
    check("err_hold", err_rows, exp_err);
  endtask

  initial begin
    int rows;
    rst_n = 1'b0; start = 1'b0; num_rows = '0; in_valid = 1'b0;
    in_val = '0; in_col = '0; in_last = 1'b0; in_eom = 1'b0; batch_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_bvalid", batch_valid, 1'b0);
    check("rst_err", err_rows, 1'b0);
    check("rst_bval", batch_val, '0);

    // Two full rows of four, last on entries 3 and 7
    q_val.delete(); q_col.delete(); q_last.delete();
    for (int i = 0; i < 8; i++) push_entry(i == 3 || i == 7);
    run_matrix(2, 0, 0);

    // Short matrix, eom without in_last forces a row end on lane 2
    q_val.delete(); q_col.delete(); q_last.delete();
    for (int i = 0; i < 3; i++) push_entry(1'b0);
    run_matrix(1, 0, 0);

    // Back-pressure for 5 cycles on the first batch
    q_val.delete(); q_col.delete(); q_last.delete();
    for (int i = 0; i < 6; i++) push_entry(i == 3);
    run_matrix(2, 2, 5);

    // Row-count mismatch: 2 row ends but 3 expected
    q_val.delete(); q_col.delete(); q_last.delete();
    for (int i = 0; i < 6; i++) push_entry(i == 2);
    run_matrix(3, 1, 0);

    // Empty matrix completes immediately and clears the held error
    @(negedge clk);
    start = 1'b1; num_rows = '0;
    @(negedge clk);
    start = 1'b0;
    check("nr0_done", done, 1'b1);
    check("nr0_err", err_rows, 1'b0);
    check("nr0_bvalid", batch_valid, 1'b0);
    @(negedge clk);
    check("nr0_pulse", done, 1'b0);
    check("nr0_busy", busy, 1'b0);

    // Reset while a batch is waiting in ISSUE
    @(negedge clk);
    start = 1'b1; num_rows = ROW_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < K; i++) begin
      in_valid = 1'b1; in_val = VAL_W'($urandom); in_col = COL_W'($urandom);
      in_last = 1'b0; in_eom = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("pre_rst_bvalid", batch_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_bvalid", batch_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done", done, 1'b0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_done", done, 1'b0);
    check("post_rst_busy", busy, 1'b0);

    // Randomized matrices, half with the correct row count
    for (int m = 0; m < 8; m++) begin
      gen_stream($urandom_range(1, 20), rows);
      run_matrix((m % 2 == 0) ? rows : $urandom_range(1, 8), m % 3, $urandom_range(1, 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
